hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  reset. Reset is asynchronous and active-low, clock is clk.
REQ-002 SHALL have ports: Rs1D, Rs2D  in  5  decode-stage source registers; Rs1E, Rs2E, RdE  in  5  execute-stage registers; ResultSrcE  in  2  execute result select.
REQ-003 SHALL have ports: PCSrcE  in  1  branch taken or jump in E; RdM, RdW  in  5  dest regs in M and W; RegWriteM, RegWriteW  in  1  write enables in M and W.
REQ-004 SHALL have ports: MduReqE  in  1  mul/div op in E; MduDone  in  1  MDU result valid; DmemReqM  in  1  data-memory access in M; DmemReady  in  1  memory completes this cycle.
REQ-005 SHALL have ports: StallF, StallD, StallE, StallM  out  1  stage-register hold; FlushD, FlushE, FlushM, FlushW  out  1  synchronous clear, with FlushE driving the execute register CLR.
REQ-006 SHALL have ports: ForwardAE, ForwardBE  out  2  operand source; MduStart  out  1  one-cycle MDU launch pulse; StateO  out  2  current FSM state.
REQ-007 SHALL have ports: StallCnt, FlushCnt  out  32  performance counters.

Function
REQ-008 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL use Rs2E with the same rules.
REQ-009 A load-use hazard SHALL exist when ResultSrcE==01, RdE!=0 and RdE equals Rs1D or Rs2D.
REQ-010 FSM states SHALL be RUN=00, MDU_WAIT=01 and MEM_WAIT=10.
REQ-011 In RUN with DmemReqM=1 and DmemReady=0: StallF, StallD, StallE and StallM SHALL be 1, FlushW SHALL be 1, MduStart SHALL be 0, and the next state SHALL be MEM_WAIT. This condition has the highest priority.
REQ-012 Otherwise, in RUN with MduReqE=1: MduStart SHALL be 1 for exactly this cycle, StallF, StallD and StallE SHALL be 1, FlushM SHALL be 1, and the next state SHALL be MDU_WAIT.
REQ-013 Otherwise, in RUN with PCSrcE=1: FlushD and FlushE SHALL be 1 and no stall SHALL be asserted. PCSrcE SHALL take priority over a load-use hazard in the same cycle.
REQ-014 Otherwise, in RUN with a load-use hazard: StallF, StallD and FlushE SHALL be 1 for one cycle, giving a one-bubble latency.
REQ-015 In MDU_WAIT with MduDone=0: the outputs of REQ-012 SHALL be held, except MduStart=0.
REQ-016 In MDU_WAIT with MduDone=1: all stalls SHALL be released in the same cycle and the next state SHALL be RUN, so the E register advances at that edge.
REQ-017 In MEM_WAIT with DmemReady=0: the outputs of REQ-011 SHALL be held. With DmemReady=1: stalls SHALL be released in the same cycle and the next state SHALL be RUN.
REQ-018 In MDU_WAIT and MEM_WAIT, PCSrcE and the load-use hazard SHALL be ignored and FlushD and FlushE SHALL be 0. The frozen E stage is re-evaluated on return to RUN.
REQ-019 In RUN with DmemReqM=1 and DmemReady=1, the FSM SHALL not stall.
REQ-020 A MduReqE pending during MEM_WAIT SHALL start only after the return to RUN.
REQ-021 MduReqE=1 together with PCSrcE=1, or together with ResultSrcE==01, is illegal. A simulation assertion SHALL flag it.

Reset
REQ-022 On rst_n=0, the state SHALL go to RUN, MduStart SHALL be 0, and StallCnt and FlushCnt SHALL be 0. This applies asynchronously, including mid MDU_WAIT or MEM_WAIT.
REQ-023 During reset, all stall and flush outputs SHALL be 0. Forward selects follow their inputs combinationally.

Configuration
REQ-024 With HAZARD_PERF_CNT_EN defined: StallCnt SHALL increment on every cycle with StallF=1, and FlushCnt SHALL increment on every cycle with FlushD=1. Both SHALL saturate at 32'hFFFFFFFF.
REQ-025 Without HAZARD_PERF_CNT_EN: the ports SHALL remain and read constant 0, and no counter flops SHALL exist.

Structure
REQ-026 Package riscv_pipe_pkg SHALL hold:
- the FSM state enum;
- RES_MEM=2'b01;
- FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-027 Forwarding select SHALL be one combinational sub-module, hazard_fwd_sel, instantiated once per operand. The FSM, stall/flush logic and counters SHALL stay in the top level.

Verification
REQ-028 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 -> ForwardAE=01.
REQ-029 ResultSrcE=01, RdE=7, Rs2D=7 -> one cycle with StallF=StallD=FlushE=1, then no stall. Adding PCSrcE=1 -> FlushD=FlushE=1 and StallF=0.
REQ-030 MduReqE=1, MduDone asserted 4 cycles later -> MduStart high 1 cycle, stalls high 4 cycles, FlushM high 4 cycles, state returns to 00.
REQ-031 DmemReqM=1, DmemReady=0 for 3 cycles with MduReqE=1 -> MEM_WAIT for 3 cycles with MduStart=0, then RUN, then MduStart pulse.
REQ-032 rst_n pulsed low during MDU_WAIT -> state 00, all outputs 0 immediately. With HAZARD_PERF_CNT_EN, 10 stall cycles -> StallCnt=10.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared hazard-unit types, result-select and forward-select encodings
package riscv_pipe_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_WAIT = 2'b01,
        MEM_WAIT = 2'b10
    } state_e;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand forward select; the M stage wins over W as it holds newer data
module hazard_fwd_sel
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);
    always_comb
        fwd = (reg_write_m && rd_m != 5'd0 && rd_m == rs_e) ? FWD_MEM :
              (reg_write_w && rd_w != 5'd0 && rd_w == rs_e) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush FSM with operand forwarding.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer
    import riscv_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MduReqE,
    input  logic        MduDone,
    input  logic        DmemReqM,
    input  logic        DmemReady,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MduStart,
    output logic [1:0]  StateO,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);
    state_e state_q, state_d;
    logic   load_use;

    hazard_fwd_sel u_fwd_a (.rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM),
                            .reg_write_w(RegWriteW), .fwd(ForwardAE));
    hazard_fwd_sel u_fwd_b (.rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM),
                            .reg_write_w(RegWriteW), .fwd(ForwardBE));

    assign load_use = ResultSrcE == RES_MEM && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    assign StateO   = state_q;

    // Outputs are gated by rst_n so nothing stalls or flushes while reset is held.
    always_comb begin
        {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduStart} = '0;
        state_d = state_q;
        if (rst_n)
            case (state_q)
                RUN:
                    if (DmemReqM && !DmemReady) begin
                        {StallF, StallD, StallE, StallM, FlushW} = '1;
                        state_d = MEM_WAIT;
                    end else if (MduReqE) begin
                        {MduStart, StallF, StallD, StallE, FlushM} = '1;
                        state_d = MDU_WAIT;
                    end else if (PCSrcE) begin
                        {FlushD, FlushE} = '1;
                    end else if (load_use) begin
                        {StallF, StallD, FlushE} = '1;
                    end
                MDU_WAIT:
                    if (!MduDone) {StallF, StallD, StallE, FlushM} = '1;
                    else state_d = RUN;
                MEM_WAIT:
                    if (!DmemReady) {StallF, StallD, StallE, StallM, FlushW} = '1;
                    else state_d = RUN;
                default:
                    state_d = RUN;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, StallF && stall_cnt_q != '1};
        flush_cnt_d = flush_cnt_q + {31'd0, FlushD && flush_cnt_q != '1};
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

    // An MDU op in E can be neither a redirect nor a load.
    a_mdu_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(MduReqE && (PCSrcE || ResultSrcE == RES_MEM)));
endmodule
